// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: command codes, TAP/FSM state types and the TAP next-state function
package jtag_master_pkg;
   typedef enum logic [1:0] {CMD_TLR, CMD_IR, CMD_DR, CMD_RUN} cmd_t;
   typedef enum logic [3:0] {
      TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR,
      TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
   } tap_state_t;
   typedef enum logic [1:0] {INIT, IDLE, SEQ, DONE} fsm_state_t;
   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      case (s)
         TAP_TLR:    return tms ? TAP_TLR    : TAP_RTI;
         TAP_RTI:    return tms ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_DR: return tms ? TAP_SEL_IR : TAP_CAP_DR;
         TAP_CAP_DR: return tms ? TAP_EX1_DR : TAP_SH_DR;
         TAP_SH_DR:  return tms ? TAP_EX1_DR : TAP_SH_DR;
         TAP_EX1_DR: return tms ? TAP_UPD_DR : TAP_PA_DR;
         TAP_PA_DR:  return tms ? TAP_EX2_DR : TAP_PA_DR;
         TAP_EX2_DR: return tms ? TAP_UPD_DR : TAP_SH_DR;
         TAP_UPD_DR: return tms ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_IR: return tms ? TAP_TLR    : TAP_CAP_IR;
         TAP_CAP_IR: return tms ? TAP_EX1_IR : TAP_SH_IR;
         TAP_SH_IR:  return tms ? TAP_EX1_IR : TAP_SH_IR;
         TAP_EX1_IR: return tms ? TAP_UPD_IR : TAP_PA_IR;
         TAP_PA_IR:  return tms ? TAP_EX2_IR : TAP_PA_IR;
         TAP_EX2_IR: return tms ? TAP_UPD_IR : TAP_SH_IR;
         default:    return tms ? TAP_SEL_DR : TAP_RTI;
      endcase
   endfunction
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides clk into TCK while run is high, with rise/fall strobes for the edge-forming clk cycle
module jtag_tck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tck,
   output logic rise_tick,
   output logic fall_tick
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   typedef logic [DW-1:0] div_t;
   div_t cnt;
   logic wrap;
   assign wrap = run && cnt == div_t'(CLK_DIV - 1);
   assign rise_tick = wrap && !tck;
   assign fall_tick = wrap && tck;
   // half-period counter; tck toggles at the end of every half-period while running
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         tck <= 1'b0;
      end else begin
         cnt <= run && !wrap ? cnt + 1'b1 : '0;
         tck <= wrap ? !tck : tck;
      end
endmodule

// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG driver running TLR/IR/DR/RUN TMS sequences and capturing TDO
module jtag_master
   import jtag_master_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int IR_LEN  = 4,
   parameter int MAX_DR  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_type,
   input  logic [4:0]        cmd_len,
   input  logic [MAX_DR-1:0] cmd_data,
   output logic              rsp_valid,
   output logic [MAX_DR-1:0] rsp_data,
   output logic              TCK,
   output logic              TMS,
   output logic              TDI,
   input  logic              TDO
);
   localparam int CW = $clog2(IR_LEN + 64);
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t MAXN = cnt_t'(MAX_DR);
   localparam cnt_t IRN  = cnt_t'(IR_LEN);
   fsm_state_t state;
   cmd_t typ;
   tap_state_t tap;
   cnt_t n, idx, pre, total;
   logic [MAX_DR-1:0] dat, cap, msk;
   logic run, rise_tick, fall_tick, tms_n, shifting, last;
   jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
      .clk(clk), .rst_n(rst_n), .run(run), .tck(TCK), .rise_tick(rise_tick), .fall_tick(fall_tick)
   );
   // TMS for the next rise (idx = rises already taken), sequence length and shift-window flag
   always_comb begin
      pre = typ == CMD_IR ? cnt_t'(4) : cnt_t'(3);
      total = typ == CMD_TLR ? cnt_t'(6) : typ == CMD_RUN ? n : pre + n + cnt_t'(2);
      tms_n = typ == CMD_TLR ? idx < cnt_t'(5) : typ == CMD_RUN ? 1'b0 :
              (idx + cnt_t'(2) < pre) || (idx + cnt_t'(1) == pre + n) || (idx == pre + n);
      shifting = tap == TAP_SH_DR || tap == TAP_SH_IR;
      last = idx == total;
   end
   // control FSM: INIT reset sequence, command accept, rise/fall handling, completion strobe
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= INIT;
         typ <= CMD_TLR;
         tap <= TAP_TLR;
         n <= '0;
         idx <= '0;
         dat <= '0;
         cap <= '0;
         msk <= '0;
         run <= 1'b0;
         TMS <= 1'b1;
         TDI <= 1'b0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: if (cmd_valid && cmd_ready) begin
               cmd_ready <= 1'b0;
               typ <= cmd_t'(cmd_type);
               n <= cmd_type == CMD_DR ? (cmd_len == 5'd0 ? cnt_t'(1) : cnt_t'(cmd_len) > MAXN ? MAXN : cnt_t'(cmd_len)) :
                    cmd_type == CMD_RUN ? cnt_t'(cmd_len) : IRN;
               idx <= '0;
               dat <= cmd_data;
               cap <= '0;
               msk <= MAX_DR'(1);
               TMS <= cmd_type != CMD_RUN;
               TDI <= 1'b0;
               run <= !(cmd_type == CMD_RUN && cmd_len == 5'd0);
               state <= cmd_type == CMD_RUN && cmd_len == 5'd0 ? DONE : SEQ;
            end
            DONE: begin
               rsp_valid <= 1'b1;
               rsp_data <= cap;
               cmd_ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               run <= 1'b1;
               if (rise_tick) begin
                  idx <= idx + cnt_t'(1);
                  tap <= tap_next(tap, TMS);
                  if (shifting) begin
                     cap <= TDO ? cap | msk : cap;
                     msk <= msk << 1;
                     dat <= dat >> 1;
                  end
               end
               if (fall_tick) begin
                  TMS <= !last && tms_n;
                  TDI <= !last && shifting && dat[0];
                  if (last) begin
                     run <= 1'b0;
                     cmd_ready <= state == INIT;
                     state <= state == INIT ? IDLE : DONE;
                  end
               end
            end
         endcase
      end
endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Host-side JTAG driver: the initiator end of the TAP interface that our TAP/core-logic block responds to.
- Accepts scan commands from a system-side valid/ready port and generates TCK/TMS/TDI from the system clock, sampling TDO.
- Tracks the TAP state, performs IR scans, DR scans, idle runs and Test-Logic-Reset sequences.
- Returns captured TDO bits on a one-cycle response strobe.

Parameters:
- CLK_DIV, 2: clk cycles per TCK half-period (>=1); TCK period = 2*CLK_DIV clk cycles.
- IR_LEN, 4: instruction register length in bits.
- MAX_DR, 16: maximum DR scan length and width of the data buses.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block idle and able to accept a command.
- cmd_type  input  2  00 TLR reset, 01 IR scan, 10 DR scan, 11 RUN idle.
- cmd_len  input  5  DR bit count or RUN TCK count; ignored for TLR and IR.
- cmd_data  input  MAX_DR  TDI bits, shifted LSB first (IR uses [IR_LEN-1:0]).
- rsp_valid  output  1  one-clk pulse when a command completes.
- rsp_data  output  MAX_DR  captured TDO bits, right-justified; bit i = i-th shifted bit.
- TCK  output  1  generated test clock, registered.
- TMS  output  1  test mode select.
- TDI  output  1  test data out to the TAP.
- TDO  input  1  test data from the TAP.

Behaviour:
- Reset (rst_n low, asynchronous): TCK=0, TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0; FSM=INIT; all counters cleared.
- TCK generation:
  - Divider counts CLK_DIV clk cycles per half-period; TCK toggles only while a sequence is active.
  - TCK idles low, and TMS holds 0 when idle (TAP parked in Run-Test/Idle).
- Edge rules:
  - TMS/TDI update only in the clk cycle TCK goes 1->0. The first bit of a sequence is set up while TCK is low, >=CLK_DIV clk before the first rise.
  - TDO is sampled in the clk cycle TCK goes 0->1, only on rises taken while the tracked TAP state is Shift-IR or Shift-DR.
- INIT (after reset release):
  - Drive TMS sequence 1,1,1,1,1,0 over 6 TCK rises, ending in Run-Test/Idle.
  - Then IDLE with cmd_ready=1. No rsp_valid for INIT.
- IDLE: the command is accepted on cmd_valid&&cmd_ready and latched; cmd_ready drops the next cycle.
- TMS sequences per command (all start and end in Run-Test/Idle):
  - TLR: 1,1,1,1,1,0.
  - IR: 1,1,0,0, then IR_LEN shift rises (TMS 0 except the last bit 1), then 1,0. Total IR_LEN+6 rises.
  - DR: 1,0,0, then N shift rises (last bit TMS=1), then 1,0. Total N+5 rises.
  - RUN: N rises with TMS=0.
- Length rules:
  - For DR, N = cmd_len, with N=0 treated as 1 and N>MAX_DR clamped to MAX_DR.
  - For RUN, N=0 completes with zero TCK rises.
- TDI during shift: cmd_data bit k on the k-th shift rise; 0 outside shift.
- TDO capture: rsp_data bits above the shift length are 0; rsp_data is 0 for TLR and RUN.
- Completion:
  - rsp_valid pulses 1 clk after the TCK fall following the final rise; rsp_data is stable from that cycle until the next completion.
  - cmd_ready returns in the same cycle as rsp_valid. rsp_valid has no backpressure.
- Tracked TAP state follows the 16-state IEEE 1149.1 graph on every rise; the FSM uses it only for shift-window detection.
- Reset mid-operation: outputs go to reset values immediately; the aborted command produces no rsp_valid, and INIT reruns after release.
- cmd_valid while busy is ignored and not queued.

Decomposition:
- Shared package jtag_master_pkg:
  - cmd_type encodings (CMD_TLR, CMD_IR, CMD_DR, CMD_RUN).
  - 4-bit TAP state enum.
  - FSM state enum (INIT, IDLE, SEQ, DONE).
- Sub-module jtag_tck_gen: divider producing TCK plus one-clk rise_tick/fall_tick strobes, with run enable. All other logic stays in jtag_master.

Test Plan (CLK_DIV=2, IR_LEN=4, MAX_DR=16):
- Release rst_n -> exactly 6 TCK rises with TMS 1,1,1,1,1,0, TCK period 4 clk; cmd_ready rises after the last fall; no rsp_valid.
- IR scan cmd_data=0x5, TDO looped to TDI -> 10 rises with TMS 1,1,0,0,0,0,0,1,1,0; TDI on rises 5-8 = 1,0,1,0; rsp_valid pulse with rsp_data=0x0005.
- DR scan len=16, data=0xA5C3, TDO from a 16-bit TAP shift model preloaded 0x1234 -> 21 rises; rsp_data=0x1234; model holds 0xA5C3.
- RUN len=5 -> 5 rises, TMS=0 throughout, rsp_data=0; RUN len=0 -> rsp_valid with no TCK activity.
- DR len=0 -> 6 rises, one shift bit; DR len=20 -> 21 rises, clamped to 16; cmd_valid pulsed while busy -> ignored.
- rst_n low at rise 7 of a DR scan -> same-cycle TCK=0, TMS=1; no rsp_valid; after release, INIT sequence 1,1,1,1,1,0 reruns.
